uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (tx_start/tx_data/tx_ready handshake) between NREQ byte-stream requesters.
  - Typical requesters: command-parser replies, CSoC data readback, scan-out dump, status banner.
- Round-robin arbitration at packet granularity. A grant is held until the requester's last byte.
- Tracks the terminal column and auto-inserts a newline once LINE_WIDTH printable bytes have been sent on a line.
- Sits between the requesters and the UART TX core, replacing the ad hoc tx_start FSM in the parser.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART TX arbiter slice.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEND   = 3'd1;
  localparam logic [2:0] NLSEND = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] NLWAIT = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;

  localparam logic [7:0] DEF_NL_CHAR    = 8'h0A;
  localparam int         DEF_LINE_WIDTH = 80;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int cand;
      cand = (int'(ptr) + k) % N;
      if (!any && req[IW'(cand)]) begin
        any               = 1'b1;
        idx               = IW'(cand);
        grant[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin sharing of one UART transmitter, with automatic
// newline insertion once a line reaches LINE_WIDTH bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NREQ         = 4,
  parameter int         LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter logic [7:0] NL_CHAR      = DEF_NL_CHAR,
  parameter int         HOLD_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic [6:0]        column_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);

  logic [2:0]      state, state_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt, req_ready_q, req_ready_nxt;
  logic [IW-1:0]   ptr_q, ptr_nxt, gidx_q, gidx_nxt, sel_idx, arb_idx;
  logic            last_q, last_nxt, tx_start_q, tx_start_nxt, busy_q, go;
  logic [7:0]      tx_data_q, tx_data_nxt, sel_byte;
  logic [6:0]      col_q, col_nxt;
  logic [HW-1:0]   hold_q, hold_nxt;
  logic [NREQ-1:0] arb_grant;
  logic            arb_any;
  logic [7:0]      lane [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane[i] = req_data_i[8*i +: 8];
  end

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // In IDLE the arbiter's pick is the candidate lane; otherwise the owner's.
  assign sel_idx  = (state == IDLE) ? arb_idx : gidx_q;
  assign sel_byte = lane[sel_idx];

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_q;
    gidx_nxt      = gidx_q;
    ptr_nxt       = ptr_q;
    last_nxt      = last_q;
    col_nxt       = col_q;
    hold_nxt      = '0;
    tx_start_nxt  = 1'b0;
    tx_data_nxt   = tx_data_q;
    req_ready_nxt = '0;
    go            = 1'b0;

    case (state)
      IDLE: begin
        if (arb_any) begin
          grant_nxt = arb_grant;
          gidx_nxt  = arb_idx;
          go        = 1'b1;
        end
      end
      SEND:   state_nxt = WAIT;
      NLSEND: state_nxt = NLWAIT;
      NLWAIT: begin
        if (tx_ready_i) begin
          col_nxt       = '0;
          state_nxt     = SEND;
          tx_start_nxt  = 1'b1;
          tx_data_nxt   = sel_byte;
          req_ready_nxt = grant_q;
          last_nxt      = req_last_i[sel_idx];
        end
      end
      WAIT: begin
        if (tx_ready_i) begin
          if (tx_data_q == NL_CHAR)
            col_nxt = '0;
          else if (col_q != 7'(LINE_WIDTH))
            col_nxt = col_q + 7'd1;
          if (last_q) begin
            grant_nxt = '0;
            ptr_nxt   = gidx_q;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_valid_i[gidx_q]) begin
          go = 1'b1;
        end else if (hold_q == HW'(HOLD_TIMEOUT - 1)) begin
          grant_nxt = '0;
          ptr_nxt   = gidx_q;
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_q + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A full line forces a newline ahead of any printable byte.
    if (go) begin
      tx_start_nxt = 1'b1;
      if (col_q == 7'(LINE_WIDTH) && sel_byte != NL_CHAR) begin
        state_nxt   = NLSEND;
        tx_data_nxt = NL_CHAR;
      end else begin
        state_nxt     = SEND;
        tx_data_nxt   = sel_byte;
        req_ready_nxt = grant_nxt;
        last_nxt      = req_last_i[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= IW'(NREQ - 1);
      last_q      <= 1'b0;
      col_q       <= '0;
      hold_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_q     <= grant_nxt;
      gidx_q      <= gidx_nxt;
      ptr_q       <= ptr_nxt;
      last_q      <= last_nxt;
      col_q       <= col_nxt;
      hold_q      <= hold_nxt;
      tx_start_q  <= tx_start_nxt;
      tx_data_q   <= tx_data_nxt;
      req_ready_q <= req_ready_nxt;
      busy_q      <= (state_nxt != IDLE);
    end
  end

  assign grant_o     = grant_q;
  assign req_ready_o = req_ready_q;
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign busy_o      = busy_q;
  assign column_o    = col_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected TX bytes and ready pulses are
// queued as stimulus is issued and a monitor checks them as the DUT emits them.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD_TIMEOUT = 1024;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NREQ-1:0] req_valid_i = '0;
  logic [8*NREQ-1:0] req_data_i = '0;
  logic [NREQ-1:0] req_last_i = '0;
  logic [NREQ-1:0] req_ready_o, grant_o;
  logic            tx_start_o, tx_ready_i, busy_o;
  logic [7:0]      tx_data_o;
  logic [6:0]      column_o;

  typedef struct {
    logic [7:0]      data;
    logic [NREQ-1:0] grant;
  } exp_t;

  exp_t exp_q[$];
  int   rdy_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   start_count = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .busy_o      (busy_o),
    .column_o    (column_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic [7:0] data, input int owner, input bit consumes);
    exp_t e;
    e.data  = data;
    e.grant = NREQ'(1) << owner;
    exp_q.push_back(e);
    if (consumes) rdy_q.push_back(owner);
  endtask

  // Drive one byte on lane idx and hold it until the DUT accepts it.
  task automatic applyStimulus(input int idx, input logic [7:0] data, input bit last);
    int cycles = 0;
    req_data_i[8*idx +: 8] = data;
    req_last_i[idx]  = last;
    req_valid_i[idx] = 1'b1;
    do begin
      @(negedge clk);
      cycles++;
    end while (!req_ready_o[idx] && cycles < 3000);
    if (!req_ready_o[idx]) checkOutput($sformatf("req_ready timeout lane %0d", idx), 0, 1);
    @(posedge clk);
    #1;
    req_valid_i[idx] = 1'b0;
    req_last_i[idx]  = 1'b0;
  endtask

  task automatic waitIdle();
    int cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy_o && cycles < 3000);
    if (busy_o) checkOutput("waitIdle timeout", 0, 1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rstn = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " grant"}, grant_o, 0);
    checkOutput({tag, " req_ready"}, req_ready_o, 0);
    checkOutput({tag, " tx_start"}, tx_start_o, 0);
    checkOutput({tag, " tx_data"}, tx_data_o, 8'h00);
    checkOutput({tag, " busy"}, busy_o, 0);
    checkOutput({tag, " column"}, column_o, 0);
  endtask

  task automatic sendLine(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'h41 + 8'(i % 26);
      if (i == 80) pushExpect(8'h0A, 0, 1'b0);
      pushExpect(b, 0, 1'b1);
      applyStimulus(0, b, i == n - 1);
    end
  endtask

  // TX core model: ready pulses 10 cycles after each start.
  initial begin
    tx_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start_o) begin
        repeat (9) @(posedge clk);
        #1 tx_ready_i = 1'b1;
        @(posedge clk);
        #1 tx_ready_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    int   who;
    forever begin
      @(negedge clk);
      if (tx_start_o) begin
        start_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected tx_start", tx_data_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_data", tx_data_o, e.data);
          checkOutput("grant at start", grant_o, e.grant);
        end
      end
      if (req_ready_o != '0) begin
        if (rdy_q.size() == 0) begin
          checkOutput("unexpected req_ready", req_ready_o, 0);
        end else begin
          who = rdy_q.pop_front();
          checkOutput("req_ready lane", req_ready_o, NREQ'(1) << who);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int cycles;
    bit seen;

    #1;
    checkResetValues("in reset");
    doReset();
    @(negedge clk);
    checkResetValues("after reset");

    // "AB" from requester 0.
    s0 = start_count;
    pushExpect(8'h41, 0, 1'b1);
    pushExpect(8'h42, 0, 1'b1);
    applyStimulus(0, 8'h41, 1'b0);
    applyStimulus(0, 8'h42, 1'b1);
    waitIdle();
    checkOutput("AB grant released", grant_o, 0);
    checkOutput("AB column", column_o, 2);
    checkOutput("AB start count", start_count - s0, 2);

    // Requesters 1 and 2 raise valid together; pointer is 0, so 1 goes first.
    pushExpect(8'h58, 1, 1'b1);
    pushExpect(8'h59, 2, 1'b1);
    fork
      applyStimulus(1, 8'h58, 1'b1);
      applyStimulus(2, 8'h59, 1'b1);
    join
    waitIdle();
    checkOutput("two-req column", column_o, 4);

    // 81 printable bytes: newline is forced ahead of byte 81.
    doReset();
    s0 = start_count;
    sendLine(81);
    waitIdle();
    checkOutput("81-byte start count", start_count - s0, 82);
    checkOutput("81-byte column", column_o, 1);

    // Exactly 80 bytes fill the line; a following newline byte is not doubled.
    doReset();
    sendLine(80);
    waitIdle();
    checkOutput("full line column", column_o, 80);
    s0 = start_count;
    pushExpect(8'h0A, 0, 1'b1);
    applyStimulus(0, 8'h0A, 1'b1);
    waitIdle();
    checkOutput("NL at wrap start count", start_count - s0, 1);
    checkOutput("NL at wrap column", column_o, 0);

    // Requester 3 stalls mid-packet; requester 0 waits, then wins after revoke.
    pushExpect(8'h61, 3, 1'b1);
    pushExpect(8'h62, 3, 1'b1);
    pushExpect(8'h5A, 0, 1'b1);
    pushExpect(8'h63, 3, 1'b1);
    applyStimulus(3, 8'h61, 1'b0);
    applyStimulus(3, 8'h62, 1'b0);
    fork
      applyStimulus(0, 8'h5A, 1'b1);
      begin
        repeat (500) @(negedge clk);
        checkOutput("grant held in hold", grant_o, 4'b1000);
        checkOutput("busy in hold", busy_o, 1);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < 1000) begin
          @(negedge clk);
          cycles++;
          if (grant_o == 4'b0001) seen = 1'b1;
        end
        checkOutput("grant passed after timeout", seen, 1);
        waitIdle();
        applyStimulus(3, 8'h63, 1'b1);
      end
    join
    waitIdle();

    // Reset while waiting on the TX core; the stale ready must be ignored.
    pushExpect(8'h51, 1, 1'b1);
    applyStimulus(1, 8'h51, 1'b1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    checkResetValues("mid-WAIT reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    s0 = start_count;
    repeat (20) @(negedge clk);
    checkResetValues("post-reset idle");
    checkOutput("no start after reset", start_count - s0, 0);
    pushExpect(8'h52, 0, 1'b1);
    applyStimulus(0, 8'h52, 1'b1);
    waitIdle();
    checkOutput("post-reset column", column_o, 1);

    checkOutput("tx queue drained", exp_q.size(), 0);
    checkOutput("ready queue drained", rdy_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
